// File: rtl/down_counter.sv
// down_counter: loadable, programmable down-counter / timer.
// Counts a loaded value down to zero and pulses a one-cycle terminal-count
// strobe (tc). With auto_reload set it reloads and keeps running, which gives
// a periodic tick every N cycles with no dead cycle.
// Optional build macro DOWN_COUNTER_PRESCALE_EN adds a PRESCALE parameter;
// while RUN, the count then decrements once per PRESCALE un-held cycles.
module down_counter #(
   parameter int WIDTH = 8
`ifdef DOWN_COUNTER_PRESCALE_EN
   ,
   parameter int PRESCALE = 4
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             tc
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;
   logic             tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;

   // The count may only move on the cycle the prescaler wraps.
   assign tick = (presc_q == PRESC_LAST);

   // Prescaler phase: restarts on any control action, frozen while held or not running.
   always_comb begin
      presc_d = presc_q;
      if (load || stop || start) begin
         presc_d = '0;
      end else if ((state_q == S_RUN) && !hold) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   // Without the prescaler every un-held RUN cycle is a decrement cycle.
   assign tick = 1'b1;
`endif

   // Next-state / next-count logic; priority is load > stop > start > hold > decrement.
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (load) begin
         reload_d = load_val;
         out_d    = load_val;
         // A reload while running restarts the count; a zero load has nothing to count.
         if ((state_q == S_RUN) && (load_val != ZERO)) begin
            state_d = S_RUN;
         end else begin
            state_d = S_IDLE;
         end
      end else if (stop) begin
         if (state_q == S_RUN) begin
            state_d = S_IDLE;
         end
      end else if (start && (state_q != S_RUN)) begin
         if (state_q == S_IDLE) begin
            if (out_q != ZERO) begin
               state_d = S_RUN;
            end
         end else begin
            // Restart from DONE re-arms from the reload register.
            out_d   = reload_q;
            state_d = (reload_q != ZERO) ? S_RUN : S_DONE;
         end
      end else if ((state_q == S_RUN) && !hold && tick) begin
         if (out_q > ONE) begin
            out_d = out_q - ONE;
         end else if (out_q == ONE) begin
            tc_d = 1'b1;
            if (auto_reload) begin
               out_d = reload_q;
            end else begin
               out_d   = ZERO;
               state_d = S_DONE;
            end
         end else begin
            // A zero count in RUN is unreachable; park safely in DONE.
            state_d = S_DONE;
         end
      end
      busy_d = (state_d == S_RUN);
   end

   // State, count, reload and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         out_q    <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         busy_q   <= busy_d;
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign tc   = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter (default build, no prescaler).
module tb_down_counter;

   logic       clk;
   logic       rst;
   logic       load;
   logic [7:0] load_val;
   logic       start;
   logic       stop;
   logic       hold;
   logic       auto_reload;
   logic [7:0] out;
   logic       busy;
   logic       tc;

   int errors = 0;
   int checks = 0;

   // Reference model: 0 = idle, 1 = running, 2 = finished.
   int         m_state;
   logic [7:0] m_out;
   logic [7:0] m_rel;
   logic       m_tc;

   down_counter #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_val    (load_val),
      .start       (start),
      .stop        (stop),
      .hold        (hold),
      .auto_reload (auto_reload),
      .out         (out),
      .busy        (busy),
      .tc          (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_out   = 8'd0;
      m_rel   = 8'd0;
      m_tc    = 1'b0;
   endtask

   // One clock of the timer's rules, applied to the model.
   task automatic model_update(input logic ld, input logic [7:0] lv, input logic st,
                               input logic sp, input logic hd, input logic ar);
      m_tc = 1'b0;
      if (ld) begin
         m_rel   = lv;
         m_out   = lv;
         m_state = (m_state == 1 && lv != 0) ? 1 : 0;
      end else if (sp) begin
         if (m_state == 1) m_state = 0;
      end else if (st && m_state == 0) begin
         if (m_out != 0) m_state = 1;
      end else if (st && m_state == 2) begin
         m_out   = m_rel;
         m_state = (m_rel != 0) ? 1 : 2;
      end else if (m_state == 1 && !hd) begin
         if (m_out == 1) begin
            m_tc = 1'b1;
            if (ar) begin
               m_out = m_rel;
            end else begin
               m_out   = 0;
               m_state = 2;
            end
         end else begin
            m_out = m_out - 8'd1;
         end
      end
   endtask

   task automatic check_model();
      chk8("out", out, m_out);
      chk1("busy", busy, (m_state == 1));
      chk1("tc", tc, m_tc);
   endtask

   // Apply one cycle of inputs, advance model, and compare after the edge.
   task automatic step(input logic ld, input logic [7:0] lv, input logic st,
                       input logic sp, input logic hd, input logic ar);
      load = ld; load_val = lv; start = st; stop = sp; hold = hd; auto_reload = ar;
      @(posedge clk);
      model_update(ld, lv, st, sp, hd, ar);
      #1;
      check_model();
      load = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   task automatic idle_step(input logic ar);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, ar);
   endtask

   initial begin
      rst = 1'b0;
      load = 1'b0; load_val = 8'd0; start = 1'b0; stop = 1'b0; hold = 1'b0; auto_reload = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk8("reset_out", out, 8'd0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_tc", tc, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Asynchronous reset in the middle of a count.
      step(1'b1, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) idle_step(1'b0);
      chk8("midcount_out", out, 8'd15);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk8("async_rst_out", out, 8'd0);
      chk1("async_rst_busy", busy, 1'b0);
      chk1("async_rst_tc", tc, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk1("start_zero_busy", busy, 1'b0);

      // One-shot count from 5.
      step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk8("oneshot_first", out, 8'd5);
      for (int k = 4; k >= 0; k--) begin
         idle_step(1'b0);
         chk8("oneshot_seq", out, 8'(k));
         chk1("oneshot_tc", tc, (k == 0));
      end
      chk1("oneshot_done_busy", busy, 1'b0);
      repeat (4) idle_step(1'b0);

      // Auto-reload period 3.
      step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 9; k++) begin
         idle_step(1'b1);
         chk1("auto_nonzero", (out != 8'd0), 1'b1);
         chk1("auto_tc_phase", tc, (k % 3 == 2));
      end
      step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Hold and stop/resume.
      step(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) idle_step(1'b0);
      chk8("hold_entry", out, 8'd7);
      repeat (4) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk8("hold_frozen", out, 8'd7);
      idle_step(1'b0);
      chk8("hold_release", out, 8'd6);
      repeat (2) idle_step(1'b0);
      step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk8("stop_out", out, 8'd4);
      chk1("stop_busy", busy, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (4) idle_step(1'b0);
      chk8("resume_end", out, 8'd0);
      chk1("resume_tc", tc, 1'b1);

      // Priority: load beats stop and start in RUN; zero load drops to IDLE.
      step(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (4) idle_step(1'b0);
      chk8("prio_entry", out, 8'd6);
      step(1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      chk8("prio_out", out, 8'd2);
      chk1("prio_busy", busy, 1'b1);
      repeat (2) idle_step(1'b0);
      chk1("prio_tc", tc, 1'b1);
      step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_step(1'b0);
      step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk1("load0_busy", busy, 1'b0);
      chk1("load0_tc", tc, 1'b0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic       r_ld, r_st, r_sp, r_hd, r_ar;
         logic [7:0] r_lv;
         r_ld = ($urandom_range(0, 15) == 0);
         r_st = ($urandom_range(0, 3) == 0);
         r_sp = ($urandom_range(0, 31) == 0);
         r_hd = ($urandom_range(0, 7) == 0);
         r_ar = $urandom_range(0, 1) == 1;
         r_lv = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
         step(r_ld, r_lv, r_st, r_sp, r_hd, r_ar);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
